// File: rtl/motor_pkg.sv
// Shared types and helpers for the elevator stepper-motor control slice.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    ARRIVE = 2'd3
  } state_e;

  localparam logic DIR_UP = 1'b1;

  // Bits needed to hold values 0..value-1, never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/motor_step_ctrl_if.sv
// Floor-move command handshake between the car dispatcher and motor_step_ctrl.
interface motor_step_ctrl_if #(
  parameter int unsigned FLOOR_W = 3
);
  logic               cmd_valid;
  logic [FLOOR_W-1:0] cmd_floor;
  logic               cmd_ready;

  modport master (output cmd_valid, output cmd_floor, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_floor, output cmd_ready);
endinterface

// File: rtl/motor_step_div.sv
// Loadable prescaler: tick_o fires on the last count of a period_i-long cycle.
// clear_i holds the count at zero and suppresses the tick.
module motor_step_div #(
  parameter int unsigned W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic [W:0] period_i,
  output logic       tick_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         term;

  assign term   = ({1'b0, cnt_q} == (period_i - (W+1)'(1)));
  assign tick_o = term && !clear_i;

  // Next count: clear, wrap on terminal count, else increment.
  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clear_i || term) cnt_d = '0;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/motor_step_ctrl.sv
// Floor-move command to paced step pulses + direction for the phase sequencer.
// Optional soft start/stop pacing is built when MOTOR_RAMP_EN is defined.
module motor_step_ctrl
  import motor_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 50000,
  parameter int unsigned STEPS_PER_FLOOR = 512,
  parameter int unsigned NUM_FLOORS      = 8,
  parameter int unsigned FLOOR_W         = 3,
  parameter int unsigned RAMP_STEPS      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  motor_step_ctrl_if.slave   cmd,
  input  logic               estop,
  output logic               step,
  output logic               dir,
  output logic               moving,
  output logic [FLOOR_W-1:0] cur_floor,
  output logic               arrived
);

  localparam int unsigned SLW = clog2((NUM_FLOORS - 1) * STEPS_PER_FLOOR + 1);
  localparam int unsigned DW  = clog2(2 * CLK_DIV);
  localparam int unsigned FCW = clog2(STEPS_PER_FLOOR);

  state_e             state_q, state_d;
  logic [FLOOR_W-1:0] target_q, target_d;
  logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d;
  logic [FLOOR_W-1:0] req_floor, floor_diff;
  logic               dir_q, dir_d;
  logic               moving_q;
  logic [SLW-1:0]     steps_left_q, steps_left_d, move_steps;
  logic [FCW-1:0]     floor_cnt_q, floor_cnt_d;
  logic [DW:0]        period;
  logic               tick, div_clear, ready_w, handshake, step_w;

  assign ready_w   = (state_q == IDLE) && !estop;
  assign handshake = cmd.cmd_valid && ready_w;
  assign div_clear = (state_q != RUN);
  assign step_w    = tick && (state_q == RUN) && !estop;

  // Clamp out-of-range floor requests to the top floor.
  always_comb begin
    req_floor = cmd.cmd_floor;
    if (int'(cmd.cmd_floor) >= int'(NUM_FLOORS)) req_floor = FLOOR_W'(NUM_FLOORS - 1);
  end

  // Total steps for the latched move.
  always_comb begin
    floor_diff = (target_q > cur_floor_q) ? (target_q - cur_floor_q) : (cur_floor_q - target_q);
    move_steps = SLW'(floor_diff) * SLW'(STEPS_PER_FLOOR);
  end

`ifdef MOTOR_RAMP_EN
  logic [SLW-1:0] total_q;
  logic [SLW-1:0] done_steps;
  logic           in_ramp;

  // Move length, kept to locate the soft-start window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 total_q <= '0;
    else if (state_q == LOAD)   total_q <= move_steps;
  end

  // Double the step period inside the soft-start or soft-stop window.
  always_comb begin
    done_steps = total_q - steps_left_q;
    in_ramp    = (int'(done_steps) < int'(RAMP_STEPS)) ||
                 (int'(steps_left_q) <= int'(RAMP_STEPS));
    period     = in_ramp ? (DW+1)'(2 * CLK_DIV) : (DW+1)'(CLK_DIV);
  end
`else
  assign period = (DW+1)'(CLK_DIV);
`endif

  motor_step_div #(.W(DW)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (div_clear),
    .period_i (period),
    .tick_o   (tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = LOAD;
      LOAD: begin
        if (estop)                         state_d = IDLE;
        else if (target_q == cur_floor_q)  state_d = ARRIVE;
        else                               state_d = RUN;
      end
      RUN: begin
        if (estop)                                        state_d = IDLE;
        else if (step_w && (steps_left_q == SLW'(1)))     state_d = ARRIVE;
      end
      ARRIVE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    cmd.cmd_ready = ready_w;
    step          = step_w;
    arrived       = (state_q == ARRIVE);
  end

  // Move datapath next-state: target latch, move setup, step accounting.
  always_comb begin
    target_d     = target_q;
    cur_floor_d  = cur_floor_q;
    dir_d        = dir_q;
    steps_left_d = steps_left_q;
    floor_cnt_d  = floor_cnt_q;
    case (state_q)
      IDLE: if (handshake) target_d = req_floor;
      LOAD: begin
        if (!estop && (target_q != cur_floor_q)) begin
          dir_d        = (target_q > cur_floor_q) ? DIR_UP : ~DIR_UP;
          steps_left_d = move_steps;
          floor_cnt_d  = '0;
        end
      end
      RUN: begin
        if (step_w) begin
          steps_left_d = steps_left_q - SLW'(1);
          if (floor_cnt_q == FCW'(STEPS_PER_FLOOR - 1)) begin
            floor_cnt_d = '0;
            cur_floor_d = (dir_q == DIR_UP) ? cur_floor_q + FLOOR_W'(1)
                                            : cur_floor_q - FLOOR_W'(1);
          end else begin
            floor_cnt_d = floor_cnt_q + FCW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Move datapath registers; moving mirrors the RUN state one-for-one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q     <= '0;
      cur_floor_q  <= '0;
      dir_q        <= 1'b0;
      steps_left_q <= '0;
      floor_cnt_q  <= '0;
      moving_q     <= 1'b0;
    end else begin
      target_q     <= target_d;
      cur_floor_q  <= cur_floor_d;
      dir_q        <= dir_d;
      steps_left_q <= steps_left_d;
      floor_cnt_q  <= floor_cnt_d;
      moving_q     <= (state_d == RUN);
    end
  end

  assign dir       = dir_q;
  assign moving    = moving_q;
  assign cur_floor = cur_floor_q;

endmodule

// File: tb/tb_motor_step_ctrl.sv
// Directed scoreboard bench for motor_step_ctrl: expected step/arrive events
// are queued when a command is issued and matched as the DUT pulses.
module tb_motor_step_ctrl;

  localparam int CLK_DIV = 4;
  localparam int SPF     = 8;
  localparam int NF      = 8;
  localparam int FW      = 4;
  localparam int RAMP    = 2;
`ifdef MOTOR_RAMP_EN
  localparam bit RAMP_ON = 1'b1;
`else
  localparam bit RAMP_ON = 1'b0;
`endif

  typedef struct {
    int t;
    bit arrive;
    int floor;
    int dir;
  } ev_t;

  logic          clk, rst_n, estop;
  logic          step, dir, moving, arrived;
  logic [FW-1:0] cur_floor;

  ev_t sbq[$];
  int  checks = 0;
  int  failures = 0;
  int  model_floor = 0;

  motor_step_ctrl_if #(.FLOOR_W(FW)) bus ();

  motor_step_ctrl #(
    .CLK_DIV         (CLK_DIV),
    .STEPS_PER_FLOOR (SPF),
    .NUM_FLOORS      (NF),
    .FLOOR_W         (FW),
    .RAMP_STEPS      (RAMP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (bus),
    .estop     (estop),
    .step      (step),
    .dir       (dir),
    .moving    (moving),
    .cur_floor (cur_floor),
    .arrived   (arrived)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one command at the current negedge and follow it through.
  // abort_k > 0 raises estop after that step; poke drives a mid-move command.
  task automatic do_move(input int cmd_f, input int abort_k, input bit poke);
    int  tgt, n, dirv, t, per, last_t, end_t, stepno, sgn;
    bit  abort_pend;
    ev_t e;
    tgt  = (cmd_f >= NF) ? NF - 1 : cmd_f;
    n    = ((tgt > model_floor) ? tgt - model_floor : model_floor - tgt) * SPF;
    dirv = (tgt > model_floor) ? 1 : 0;
    sgn  = dirv ? 1 : -1;
    t    = 1;
    for (int k = 1; k <= n; k++) begin
      if (abort_k != 0 && k > abort_k) break;
      per = (RAMP_ON && (k <= RAMP || k > n - RAMP)) ? 2 * CLK_DIV : CLK_DIV;
      t  += per;
      e.t = t; e.arrive = 1'b0; e.floor = model_floor + sgn * ((k - 1) / SPF); e.dir = dirv;
      sbq.push_back(e);
    end
    last_t = t;
    if (abort_k == 0) begin
      e.t = t + 1; e.arrive = 1'b1; e.floor = tgt; e.dir = dirv;
      sbq.push_back(e);
      last_t = t + 1;
    end
    end_t = last_t + 4 * CLK_DIV + 4;

    chk("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_floor = FW'(cmd_f);
    @(negedge clk);
    t = 1;
    bus.cmd_valid = 1'b0;
    chk("ready_after_hs", bus.cmd_ready, 0);
    chk("moving_in_load", moving, 0);
    stepno = 0;
    abort_pend = 1'b0;
    while (t <= end_t) begin
      if (abort_pend) begin
        estop = 1'b1;
        abort_pend = 1'b0;
      end
      if (poke && t == 10) begin
        chk("ready_busy", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_floor = FW'(7);
      end
      if (poke && t == 14) bus.cmd_valid = 1'b0;
      if (step === 1'b1 || arrived === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("stray_pulse", {step, arrived}, 0);
        end else begin
          e = sbq.pop_front();
          chk("evt_time", t, e.t);
          chk("evt_kind_arrived", arrived, e.arrive);
          chk("evt_cur_floor", cur_floor, e.floor);
          chk("evt_moving", moving, e.arrive ? 0 : 1);
          if (!e.arrive) begin
            chk("evt_dir", dir, e.dir);
            stepno++;
            if (abort_k != 0 && stepno == abort_k) abort_pend = 1'b1;
          end
        end
      end else if (sbq.size() != 0 && t >= sbq[0].t) begin
        e = sbq.pop_front();
        chk("evt_missing", {step, arrived}, e.arrive ? 1 : 2);
      end
      @(negedge clk);
      t++;
    end
    chk("queue_drained", sbq.size(), 0);
    sbq.delete();

    if (abort_k == 0) begin
      chk("end_cur_floor", cur_floor, tgt);
      chk("end_ready", bus.cmd_ready, 1);
      model_floor = tgt;
    end else begin
      chk("abort_cur_floor", cur_floor, model_floor + sgn * (abort_k / SPF));
      chk("abort_dir_held", dir, dirv);
      chk("abort_moving", moving, 0);
      chk("abort_ready_low", bus.cmd_ready, 0);
      estop = 1'b0;
      @(negedge clk);
      chk("abort_ready_back", bus.cmd_ready, 1);
      model_floor = model_floor + sgn * (abort_k / SPF);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    estop = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_floor = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_moving", moving, 0);
    chk("rst_cur_floor", cur_floor, 0);
    chk("rst_arrived", arrived, 0);

    // Up two floors, back down, then a same-floor request.
    do_move(2, 0, 1'b0);
    do_move(0, 0, 1'b0);
    do_move(0, 0, 1'b0);

    // Emergency stop after step 11 of a 0->2 move.
    do_move(2, 11, 1'b0);

    // Mid-move command ignored; out-of-range request clamps to top floor.
    do_move(2, 0, 1'b1);
    do_move(9, 0, 1'b0);

    // Asynchronous reset in the middle of a downward move.
    bus.cmd_valid = 1'b1;
    bus.cmd_floor = FW'(5);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_reset_moving", moving, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_cur_floor", cur_floor, 0);
    chk("async_rst_moving", moving, 0);
    chk("async_rst_dir", dir, 0);
    chk("async_rst_step", step, 0);
    chk("async_rst_arrived", arrived, 0);
    chk("async_rst_ready", bus.cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_floor = 0;
    @(negedge clk);

    // Single-floor move (ramp pacing applies when built with MOTOR_RAMP_EN).
    do_move(1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
